// File: rtl/mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_responder_pkg
// Shared constants and types for the main-memory responder that sits below the
// instruction and data caches.
//   LINE_SIZE    : cache line width in bits
//   MEM_LATENCY  : default request-to-response latency in cycles
//   mem_state_e  : responder FSM state encodings (MEM_IDLE / MEM_WAIT / MEM_RESP)
//   mem_port_e   : initiator port identifiers (icache / dcache)
// -----------------------------------------------------------------------------
package mem_responder_pkg;

    localparam int LINE_SIZE    = 32'd128;
    localparam int MEM_LATENCY  = 32'd5;
    localparam int LAT_CNT_BITS = 32'd8;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_RESP = 2'd2
    } mem_state_e;

    typedef enum logic {
        PORT_IC = 1'b0,
        PORT_DC = 1'b1
    } mem_port_e;

    // Round-robin tie break: the port that was not served last wins.
    function automatic mem_port_e rr_pick(input mem_port_e last_grant);
        return (last_grant == PORT_IC) ? PORT_DC : PORT_IC;
    endfunction

endpackage

// File: rtl/mem_line_array.sv
// -----------------------------------------------------------------------------
// mem_line_array
// DEPTH_LINES x LINE_BITS single-port backing store for main memory.
// Reads are combinational from the addressed line; writes happen on the rising
// clock edge when wr_en is high. Contents are never cleared by reset.
// Ports:
//   clk    : clock
//   wr_en  : write enable for the addressed line
//   addr   : line index
//   wdata  : line to be written
//   rdata  : line currently stored at addr
// -----------------------------------------------------------------------------
module mem_line_array
    import mem_responder_pkg::*;
#(
    parameter int LINE_BITS   = LINE_SIZE,
    parameter int DEPTH_LINES = 32'd4096
) (
    input  logic                           clk,
    input  logic                           wr_en,
    input  logic [$clog2(DEPTH_LINES)-1:0] addr,
    input  logic [LINE_BITS-1:0]           wdata,
    output logic [LINE_BITS-1:0]           rdata
);

    logic [LINE_BITS-1:0] mem_r [DEPTH_LINES];

    // Line write on the clock edge.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[addr] <= wdata;
        end
    end

    assign rdata = mem_r[addr];

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Main-memory responder serving line fills for the icache and fills/writebacks
// for the dcache. One request is serviced at a time: the arbiter grants a port
// in IDLE, the FSM waits out a fixed latency in WAIT, performs the array access
// on the last WAIT cycle, and raises the granted port's response strobe in RESP.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   ic_req_valid    : icache line read request (held until ic_resp_valid)
//   ic_req_addr     : icache byte address (line offset ignored)
//   ic_resp_valid   : one-cycle icache response strobe
//   ic_resp_data    : icache read line (held until the next icache response)
//   dc_req_valid    : dcache request (held until dc_resp_valid)
//   dc_req_write    : 1 = writeback, 0 = fill
//   dc_req_addr     : dcache byte address (line offset ignored)
//   dc_req_wdata    : writeback line
//   dc_resp_valid   : one-cycle dcache response strobe
//   dc_resp_data    : fill data, or echo of the written line
//   busy            : high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int LINE_BITS   = LINE_SIZE,
    parameter int ADDR_BITS   = 32'd32,
    parameter int LATENCY     = MEM_LATENCY,
    parameter int DEPTH_LINES = 32'd4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ic_req_valid,
    input  logic [ADDR_BITS-1:0] ic_req_addr,
    output logic                 ic_resp_valid,
    output logic [LINE_BITS-1:0] ic_resp_data,
    input  logic                 dc_req_valid,
    input  logic                 dc_req_write,
    input  logic [ADDR_BITS-1:0] dc_req_addr,
    input  logic [LINE_BITS-1:0] dc_req_wdata,
    output logic                 dc_resp_valid,
    output logic [LINE_BITS-1:0] dc_resp_data,
    output logic                 busy
);

    localparam int OFF_BITS = $clog2(LINE_BITS / 32'd8);
    localparam int IDX_BITS = $clog2(DEPTH_LINES);
    // Grant cycle and RESP cycle account for two of the LATENCY cycles.
    localparam logic [LAT_CNT_BITS-1:0] CNT_LOAD = LAT_CNT_BITS'(LATENCY - 32'd2);

    // Line index: drop the byte offset, keep the low IDX_BITS (addresses wrap).
    function automatic logic [IDX_BITS-1:0] line_index(input logic [ADDR_BITS-1:0] addr);
        return addr[OFF_BITS +: IDX_BITS];
    endfunction

    mem_state_e              state_r;
    mem_state_e              state_next_s;
    mem_port_e               grant_port_r;
    mem_port_e               last_grant_r;
    mem_port_e               grant_sel_s;
    logic                    grant_s;
    logic [IDX_BITS-1:0]     index_r;
    logic                    write_r;
    logic [LINE_BITS-1:0]    wdata_r;
    logic [LAT_CNT_BITS-1:0] cnt_r;
    logic                    done_s;
    logic                    arr_we_s;
    logic [LINE_BITS-1:0]    arr_rdata_s;
    logic                    ic_resp_valid_s;
    logic                    dc_resp_valid_s;
    logic [LINE_BITS-1:0]    ic_resp_data_s;
    logic [LINE_BITS-1:0]    dc_resp_data_s;
    logic                    unused_addr_bits_s;

    // Offset bits and bits above the wrapped index carry no information here.
    assign unused_addr_bits_s = ^{ic_req_addr[OFF_BITS-1:0],
                                  ic_req_addr[ADDR_BITS-1:OFF_BITS+IDX_BITS],
                                  dc_req_addr[OFF_BITS-1:0],
                                  dc_req_addr[ADDR_BITS-1:OFF_BITS+IDX_BITS]};

    // Last WAIT cycle: the array access happens at the end of this cycle.
    assign done_s   = (state_r == MEM_WAIT) && (cnt_r == {LAT_CNT_BITS{1'b0}});
    // Reset in the same cycle abandons the write.
    assign arr_we_s = done_s && write_r && !rst;

    mem_line_array #(
        .LINE_BITS  (LINE_BITS),
        .DEPTH_LINES(DEPTH_LINES)
    ) u_array (
        .clk  (clk),
        .wr_en(arr_we_s),
        .addr (index_r),
        .wdata(wdata_r),
        .rdata(arr_rdata_s)
    );

    // Arbiter: grant only in IDLE; a tie goes to the port not served last.
    always_comb begin
        grant_s     = 1'b0;
        grant_sel_s = PORT_IC;
        if (state_r == MEM_IDLE) begin
            if (ic_req_valid && dc_req_valid) begin
                grant_s     = 1'b1;
                grant_sel_s = rr_pick(last_grant_r);
            end else if (dc_req_valid) begin
                grant_s     = 1'b1;
                grant_sel_s = PORT_DC;
            end else if (ic_req_valid) begin
                grant_s     = 1'b1;
                grant_sel_s = PORT_IC;
            end else begin
                grant_s     = 1'b0;
                grant_sel_s = PORT_IC;
            end
        end else begin
            grant_s     = 1'b0;
            grant_sel_s = PORT_IC;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= MEM_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = MEM_IDLE;
        case (state_r)
            MEM_IDLE: state_next_s = grant_s ? MEM_WAIT : MEM_IDLE;
            MEM_WAIT: state_next_s = done_s ? MEM_RESP : MEM_WAIT;
            MEM_RESP: state_next_s = MEM_IDLE;
            default:  state_next_s = MEM_IDLE;
        endcase
    end

    // Request latch at grant, latency countdown, and round-robin history.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_port_r <= PORT_IC;
            last_grant_r <= PORT_IC;
            index_r      <= {IDX_BITS{1'b0}};
            write_r      <= 1'b0;
            wdata_r      <= {LINE_BITS{1'b0}};
            cnt_r        <= {LAT_CNT_BITS{1'b0}};
        end else begin
            if (grant_s) begin
                grant_port_r <= grant_sel_s;
                index_r      <= (grant_sel_s == PORT_DC) ? line_index(dc_req_addr)
                                                         : line_index(ic_req_addr);
                write_r      <= (grant_sel_s == PORT_DC) ? dc_req_write : 1'b0;
                wdata_r      <= dc_req_wdata;
                cnt_r        <= CNT_LOAD;
            end else if ((state_r == MEM_WAIT) && !done_s) begin
                cnt_r <= cnt_r - {{(LAT_CNT_BITS-1){1'b0}}, 1'b1};
            end
            if (state_r == MEM_RESP) begin
                last_grant_r <= grant_port_r;
            end
        end
    end

    // Output next values: strobe and data are staged on the last WAIT cycle
    // so they appear, registered, during RESP.
    always_comb begin
        ic_resp_valid_s = 1'b0;
        dc_resp_valid_s = 1'b0;
        ic_resp_data_s  = ic_resp_data;
        dc_resp_data_s  = dc_resp_data;
        if (done_s) begin
            if (grant_port_r == PORT_DC) begin
                dc_resp_valid_s = 1'b1;
                dc_resp_data_s  = write_r ? wdata_r : arr_rdata_s;
            end else begin
                ic_resp_valid_s = 1'b1;
                ic_resp_data_s  = arr_rdata_s;
            end
        end else begin
            ic_resp_valid_s = 1'b0;
            dc_resp_valid_s = 1'b0;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            ic_resp_valid <= 1'b0;
            dc_resp_valid <= 1'b0;
            ic_resp_data  <= {LINE_BITS{1'b0}};
            dc_resp_data  <= {LINE_BITS{1'b0}};
            busy          <= 1'b0;
        end else begin
            ic_resp_valid <= ic_resp_valid_s;
            dc_resp_valid <= dc_resp_valid_s;
            ic_resp_data  <= ic_resp_data_s;
            dc_resp_data  <= dc_resp_data_s;
            busy          <= (state_next_s != MEM_IDLE);
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    logic         clk;
    logic         rst;
    logic         ic_req_valid;
    logic [31:0]  ic_req_addr;
    logic         ic_resp_valid;
    logic [127:0] ic_resp_data;
    logic         dc_req_valid;
    logic         dc_req_write;
    logic [31:0]  dc_req_addr;
    logic [127:0] dc_req_wdata;
    logic         dc_resp_valid;
    logic [127:0] dc_resp_data;
    logic         busy;

    int pass_cnt;
    int total_cnt;

    localparam logic [127:0] D1 = 128'h11112222333344445555666677778888;
    localparam logic [127:0] D2 = 128'hA5A5A5A5_00000001_5A5A5A5A_00000002;
    localparam logic [127:0] D3 = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    localparam logic [127:0] D4 = 128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0;
    localparam logic [127:0] D5 = 128'hCAFEF00D_00000003_CAFEF00D_00001003;
    localparam logic [127:0] D6 = 128'h66666666_66666666_66666666_66666666;
    localparam logic [127:0] D7 = 128'h77777777_77777777_77777777_77777777;
    localparam logic [127:0] D8 = 128'h88888888_00000000_88888888_00000000;

    mem_responder #(
        .LINE_BITS  (128),
        .ADDR_BITS  (32),
        .LATENCY    (5),
        .DEPTH_LINES(4096)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ic_req_valid (ic_req_valid),
        .ic_req_addr  (ic_req_addr),
        .ic_resp_valid(ic_resp_valid),
        .ic_resp_data (ic_resp_data),
        .dc_req_valid (dc_req_valid),
        .dc_req_write (dc_req_write),
        .dc_req_addr  (dc_req_addr),
        .dc_req_wdata (dc_req_wdata),
        .dc_resp_valid(dc_resp_valid),
        .dc_resp_data (dc_resp_data),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count falling edges until the wanted port responds (bounded at 40).
    task automatic wait_resp(input logic want_dc, output int cyc, output logic other_seen);
        cyc = 0;
        other_seen = 1'b0;
        do begin
            @(negedge clk);
            cyc++;
            if (want_dc ? ic_resp_valid : dc_resp_valid) other_seen = 1'b1;
        end while (!(want_dc ? dc_resp_valid : ic_resp_valid) && cyc < 40);
    endtask

    // One complete dcache transaction; request dropped on the response cycle.
    task automatic run_dc(input logic wr, input logic [31:0] addr, input logic [127:0] wd,
                          output int cyc, output logic [127:0] data, output logic other);
        @(negedge clk);
        dc_req_valid = 1'b1;
        dc_req_write = wr;
        dc_req_addr  = addr;
        dc_req_wdata = wd;
        wait_resp(1'b1, cyc, other);
        data = dc_resp_data;
        dc_req_valid = 1'b0;
    endtask

    // One complete icache transaction.
    task automatic run_ic(input logic [31:0] addr,
                          output int cyc, output logic [127:0] data, output logic other);
        @(negedge clk);
        ic_req_valid = 1'b1;
        ic_req_addr  = addr;
        wait_resp(1'b0, cyc, other);
        data = ic_resp_data;
        ic_req_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
        total_cnt++; if (ic_resp_valid !== 1'b0) $display("FAIL reset_ic_valid: got %b expected 0", ic_resp_valid); else pass_cnt++;
        total_cnt++; if (dc_resp_valid !== 1'b0) $display("FAIL reset_dc_valid: got %b expected 0", dc_resp_valid); else pass_cnt++;
        total_cnt++; if (ic_resp_data !== 128'h0) $display("FAIL reset_ic_data: got %h expected 0", ic_resp_data); else pass_cnt++;
        total_cnt++; if (dc_resp_data !== 128'h0) $display("FAIL reset_dc_data: got %h expected 0", dc_resp_data); else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_write_read;
        int cyc; logic [127:0] data; logic other;
        run_dc(1'b1, 32'h40, D1, cyc, data, other);
        total_cnt++; if (cyc !== 5) $display("FAIL wr_latency: got %0d expected 5", cyc); else pass_cnt++;
        total_cnt++; if (data !== D1) $display("FAIL wr_echo: got %h expected %h", data, D1); else pass_cnt++;
        total_cnt++; if (other !== 1'b0) $display("FAIL wr_ic_quiet: got %b expected 0", other); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (dc_resp_valid !== 1'b0) $display("FAIL wr_pulse_width: got %b expected 0", dc_resp_valid); else pass_cnt++;
        run_ic(32'h40, cyc, data, other);
        total_cnt++; if (cyc !== 5) $display("FAIL ic_latency: got %0d expected 5", cyc); else pass_cnt++;
        total_cnt++; if (data !== D1) $display("FAIL ic_data: got %h expected %h", data, D1); else pass_cnt++;
        total_cnt++; if (other !== 1'b0) $display("FAIL ic_dc_quiet: got %b expected 0", other); else pass_cnt++;
    endtask

    task automatic test_arbitration;
        int cyc; logic [127:0] data; logic other;
        run_dc(1'b1, 32'h80, D4, cyc, data, other);
        total_cnt++; if (cyc !== 5) $display("FAIL arb_prewrite: got %0d expected 5", cyc); else pass_cnt++;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        // Tie right after reset; dcache keeps requesting afterwards.
        ic_req_valid = 1'b1; ic_req_addr = 32'h40;
        dc_req_valid = 1'b1; dc_req_write = 1'b0; dc_req_addr = 32'h80;
        wait_resp(1'b1, cyc, other);
        total_cnt++; if (cyc !== 5) $display("FAIL arb_dc_first_latency: got %0d expected 5", cyc); else pass_cnt++;
        total_cnt++; if (dc_resp_data !== D4) $display("FAIL arb_dc_data: got %h expected %h", dc_resp_data, D4); else pass_cnt++;
        total_cnt++; if (other !== 1'b0) $display("FAIL arb_ic_not_first: got %b expected 0", other); else pass_cnt++;
        // Next tie (both still high) goes to the icache.
        wait_resp(1'b0, cyc, other);
        total_cnt++; if (cyc !== 6) $display("FAIL arb_ic_spacing: got %0d expected 6", cyc); else pass_cnt++;
        total_cnt++; if (ic_resp_data !== D1) $display("FAIL arb_ic_data: got %h expected %h", ic_resp_data, D1); else pass_cnt++;
        total_cnt++; if (other !== 1'b0) $display("FAIL arb_dc_not_second: got %b expected 0", other); else pass_cnt++;
        ic_req_valid = 1'b0;
        wait_resp(1'b1, cyc, other);
        total_cnt++; if (cyc !== 6) $display("FAIL arb_dc_third_spacing: got %0d expected 6", cyc); else pass_cnt++;
        total_cnt++; if (dc_resp_data !== D4) $display("FAIL arb_dc_third_data: got %h expected %h", dc_resp_data, D4); else pass_cnt++;
        dc_req_valid = 1'b0;
    endtask

    task automatic test_back_to_back;
        int cyc; logic other;
        @(negedge clk);
        dc_req_valid = 1'b1; dc_req_write = 1'b0; dc_req_addr = 32'h40;
        wait_resp(1'b1, cyc, other);
        total_cnt++; if (cyc !== 5) $display("FAIL b2b_first_latency: got %0d expected 5", cyc); else pass_cnt++;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total_cnt++; if (dc_resp_valid !== 1'b0) $display("FAIL b2b_pulse_width_%0d: got %b expected 0", i, dc_resp_valid); else pass_cnt++;
            total_cnt++; if (busy !== 1'b0) $display("FAIL b2b_idle_busy_%0d: got %b expected 0", i, busy); else pass_cnt++;
            // One idle cycle already elapsed; 5 more gives a spacing of 6.
            wait_resp(1'b1, cyc, other);
            total_cnt++; if (cyc !== 5) $display("FAIL b2b_spacing_%0d: got %0d expected 5 (plus 1 idle)", i, cyc); else pass_cnt++;
            total_cnt++; if (dc_resp_data !== D1) $display("FAIL b2b_data_%0d: got %h expected %h", i, dc_resp_data, D1); else pass_cnt++;
        end
        dc_req_valid = 1'b0;
    endtask

    task automatic test_reset_mid;
        int cyc; logic [127:0] data; logic other; logic seen;
        run_dc(1'b1, 32'h100, D2, cyc, data, other);
        total_cnt++; if (data !== D2) $display("FAIL rstmid_prewrite: got %h expected %h", data, D2); else pass_cnt++;
        @(negedge clk);
        dc_req_valid = 1'b1; dc_req_write = 1'b1; dc_req_addr = 32'h100; dc_req_wdata = D3;
        @(negedge clk);
        total_cnt++; if (busy !== 1'b1) $display("FAIL rstmid_busy_wait: got %b expected 1", busy); else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; dc_req_valid = 1'b0;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rstmid_busy_after: got %b expected 0", busy); else pass_cnt++;
        total_cnt++; if (dc_resp_data !== 128'h0) $display("FAIL rstmid_dc_data: got %h expected 0", dc_resp_data); else pass_cnt++;
        seen = dc_resp_valid;
        repeat (8) begin
            @(negedge clk);
            if (dc_resp_valid) seen = 1'b1;
        end
        total_cnt++; if (seen !== 1'b0) $display("FAIL rstmid_no_resp: got %b expected 0", seen); else pass_cnt++;
        run_dc(1'b0, 32'h100, 128'h0, cyc, data, other);
        total_cnt++; if (cyc !== 5) $display("FAIL rstmid_read_latency: got %0d expected 5", cyc); else pass_cnt++;
        total_cnt++; if (data !== D2) $display("FAIL rstmid_no_commit: got %h expected %h", data, D2); else pass_cnt++;
    endtask

    task automatic test_wrap;
        int cyc; logic [127:0] data; logic other;
        // Line index 4096+3 -> byte address 0x10030; wraps onto index 3 (0x30).
        run_dc(1'b1, 32'h0001_0030, D5, cyc, data, other);
        total_cnt++; if (cyc !== 5) $display("FAIL wrap_write_latency: got %0d expected 5", cyc); else pass_cnt++;
        run_dc(1'b0, 32'h0000_0030, 128'h0, cyc, data, other);
        total_cnt++; if (data !== D5) $display("FAIL wrap_read: got %h expected %h", data, D5); else pass_cnt++;
    endtask

    task automatic test_payload_change;
        int cyc; logic [127:0] data; logic other;
        run_dc(1'b1, 32'h300, D8, cyc, data, other);
        total_cnt++; if (data !== D8) $display("FAIL latch_prewrite: got %h expected %h", data, D8); else pass_cnt++;
        @(negedge clk);
        dc_req_valid = 1'b1; dc_req_write = 1'b1; dc_req_addr = 32'h200; dc_req_wdata = D6;
        @(negedge clk);
        dc_req_addr = 32'h300; dc_req_wdata = D7;
        wait_resp(1'b1, cyc, other);
        total_cnt++; if (cyc !== 4) $display("FAIL latch_latency: got %0d expected 4 (plus 1 before change)", cyc); else pass_cnt++;
        total_cnt++; if (dc_resp_data !== D6) $display("FAIL latch_echo: got %h expected %h", dc_resp_data, D6); else pass_cnt++;
        dc_req_valid = 1'b0;
        run_dc(1'b0, 32'h200, 128'h0, cyc, data, other);
        total_cnt++; if (data !== D6) $display("FAIL latch_array_200: got %h expected %h", data, D6); else pass_cnt++;
        run_dc(1'b0, 32'h300, 128'h0, cyc, data, other);
        total_cnt++; if (data !== D8) $display("FAIL latch_array_300: got %h expected %h", data, D8); else pass_cnt++;
    endtask

    initial begin
        pass_cnt     = 0;
        total_cnt    = 0;
        rst          = 1'b1;
        ic_req_valid = 1'b0;
        ic_req_addr  = 32'h0;
        dc_req_valid = 1'b0;
        dc_req_write = 1'b0;
        dc_req_addr  = 32'h0;
        dc_req_wdata = 128'h0;
        test_reset();
        test_write_read();
        test_arbitration();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        test_payload_change();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
